// File: rtl/tug_pkg.sv
// -----------------------------------------------------------------------------
// tug_pkg
// Shared types and constants for the tug-of-war round/match sequencer.
//   state_e   : sequencer state (HOLD, PLAY, SCORE, DONE), 2-bit encoded
//   WIN_*     : encodings of the winner output
//   sat_inc   : score increment that never passes the match-winning value
// -----------------------------------------------------------------------------
package tug_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    PLAY  = 2'd1,
    SCORE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RIGHT = 2'b01;
  localparam logic [1:0] WIN_LEFT  = 2'b10;

  // Holds at max instead of wrapping, so a score can never roll past the
  // winning value even if a point were somehow credited after the match ends.
  function automatic logic [2:0] sat_inc(input logic [2:0] s, input logic [2:0] max);
    return (s >= max) ? s : s + 3'd1;
  endfunction

endpackage

// File: rtl/tug_match_ctrl_if.sv
// -----------------------------------------------------------------------------
// tug_match_ctrl_if
// Bundle of the press inputs, edge-light inputs and all sequencer outputs.
//   master : press/edge source side (drives l_req, r_req, left_edge, right_edge)
//   slave  : the sequencer (drives grants, next_round, scores, match_over,
//            winner, state_o)
// -----------------------------------------------------------------------------
interface tug_match_ctrl_if;
  logic       l_req;
  logic       r_req;
  logic       left_edge;
  logic       right_edge;
  logic       l_grant;
  logic       r_grant;
  logic       next_round;
  logic [2:0] l_score;
  logic [2:0] r_score;
  logic       match_over;
  logic [1:0] winner;
  logic [1:0] state_o;

  modport master (
    output l_req, r_req, left_edge, right_edge,
    input  l_grant, r_grant, next_round, l_score, r_score, match_over, winner, state_o
  );

  modport slave (
    input  l_req, r_req, left_edge, right_edge,
    output l_grant, r_grant, next_round, l_score, r_score, match_over, winner, state_o
  );
endinterface

// File: rtl/tug_match_ctrl_round_timer.sv
// -----------------------------------------------------------------------------
// round_timer
// Loadable down-counter that stops at zero. One instance times both the
// pre-round hold-off and the in-round timeout.
//   clk, reset : clock, asynchronous active-high reset (count <= RESET_VAL)
//   load       : load load_val this cycle (has priority over en)
//   load_val   : value to load
//   en         : decrement by one when nonzero
//   zero       : count is currently zero
// -----------------------------------------------------------------------------
module round_timer #(
  parameter int unsigned   TW        = 16,
  parameter logic [TW-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/tug_match_ctrl.sv
// -----------------------------------------------------------------------------
// tug_match_ctrl
// Round and match sequencer for the tug-of-war light chain. Arbitrates the two
// press pulses into the chain, detects round wins from the edge lights, pulses
// next_round to re-centre the chain, and keeps score until one side reaches
// WIN_SCORE.
//   clk, reset : clock, asynchronous active-high reset
//   bus.l_req, bus.r_req          : cyber / human single-cycle press pulses
//   bus.left_edge, bus.right_edge : edge lights of the chain
//   bus.l_grant, bus.r_grant      : arbitrated presses (combinational)
//   bus.next_round                : one-cycle re-centre pulse (SCORE state)
//   bus.l_score, bus.r_score      : per-side points
//   bus.match_over, bus.winner    : match result
//   bus.state_o                   : current state for debug display
// -----------------------------------------------------------------------------
module tug_match_ctrl
  import tug_pkg::*;
#(
  parameter int unsigned WIN_SCORE = 7,
  parameter int unsigned HOLDOFF   = 8,
  parameter int unsigned TIMEOUT   = 0,
  parameter int unsigned TW        = 16
) (
  input  logic             clk,
  input  logic             reset,
  tug_match_ctrl_if.slave  bus
);

  localparam logic [2:0]    WIN_VAL    = 3'(WIN_SCORE);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLDOFF);
  localparam bit            TIMEOUT_EN = (TIMEOUT != 0);
  // The timer reports zero on the last PLAY cycle, so TIMEOUT-1 gives exactly
  // TIMEOUT cycles of PLAY before a draw.
  localparam logic [TW-1:0] PLAY_LOAD  = TIMEOUT_EN ? TW'(TIMEOUT - 1) : '0;

  state_e     state_q,   state_d;
  logic [2:0] l_score_q, l_score_d;
  logic [2:0] r_score_q, r_score_d;
  logic [1:0] winner_q,  winner_d;

  logic          l_grant;
  logic          r_grant;
  logic          next_round;
  logic          match_over;
  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic          tmr_en;
  logic          tmr_zero;

  round_timer #(
    .TW        (TW),
    .RESET_VAL (HOLD_LOAD)
  ) u_round_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    l_score_d    = l_score_q;
    r_score_d    = r_score_q;
    winner_d     = winner_q;
    l_grant      = 1'b0;
    r_grant      = 1'b0;
    next_round   = 1'b0;
    match_over   = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = HOLD_LOAD;
    tmr_en       = 1'b0;

    unique case (state_q)
      HOLD: begin
        // Presses are simply not granted here; nothing is queued.
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d      = PLAY;
          tmr_load     = 1'b1;
          tmr_load_val = PLAY_LOAD;
        end
      end

      PLAY: begin
        // Simultaneous presses cancel each other out.
        l_grant = bus.l_req & ~bus.r_req;
        r_grant = bus.r_req & ~bus.l_req;
        tmr_en  = TIMEOUT_EN;
        // A point on the timeout cycle takes precedence over the draw.
        if (l_grant && bus.left_edge) begin
          state_d   = SCORE;
          l_score_d = sat_inc(l_score_q, WIN_VAL);
        end else if (r_grant && bus.right_edge) begin
          state_d   = SCORE;
          r_score_d = sat_inc(r_score_q, WIN_VAL);
        end else if (TIMEOUT_EN && tmr_zero) begin
          state_d = SCORE;
        end
      end

      SCORE: begin
        next_round = 1'b1;
        if (l_score_q == WIN_VAL) begin
          state_d  = DONE;
          winner_d = WIN_LEFT;
        end else if (r_score_q == WIN_VAL) begin
          state_d  = DONE;
          winner_d = WIN_RIGHT;
        end else begin
          state_d      = HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = HOLD_LOAD;
        end
      end

      DONE: begin
        match_over = 1'b1;
      end

      default: begin
        state_d = HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HOLD;
      l_score_q <= 3'd0;
      r_score_q <= 3'd0;
      winner_q  <= WIN_NONE;
    end else begin
      state_q   <= state_d;
      l_score_q <= l_score_d;
      r_score_q <= r_score_d;
      winner_q  <= winner_d;
    end
  end

  assign bus.l_grant    = l_grant;
  assign bus.r_grant    = r_grant;
  assign bus.next_round = next_round;
  assign bus.l_score    = l_score_q;
  assign bus.r_score    = r_score_q;
  assign bus.match_over = match_over;
  assign bus.winner     = winner_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_tug_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tug_match_ctrl
// Table-driven bench for tug_match_ctrl (WIN_SCORE=2, HOLDOFF=3, TIMEOUT=5).
// Each table row gives one cycle of inputs plus the outputs expected during
// that cycle; expectations are queued when the row is driven and popped when
// the outputs are sampled on the falling edge. Reset pulses are hand-written
// and check the asynchronous clear without any clock edge.
// -----------------------------------------------------------------------------
module tb_tug_match_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  tug_match_ctrl_if bus ();

  tug_match_ctrl #(
    .WIN_SCORE (2),
    .HOLDOFF   (3),
    .TIMEOUT   (5),
    .TW        (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       lg, rg, nr;
    logic [1:0] st;
    logic [2:0] ls, rs;
    logic       mo;
    logic [1:0] win;
    int         id;
  } exp_t;

  typedef struct {
    logic do_reset;
    logic l, r, le, re;
    exp_t e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(logic rst, logic l, logic r, logic le, logic re,
                              logic lg, logic rg, logic nr, logic [1:0] st,
                              logic [2:0] ls, logic [2:0] rs, logic mo, logic [1:0] win);
    vec_t v;
    v.do_reset = rst;
    v.l = l; v.r = r; v.le = le; v.re = re;
    v.e.lg = lg; v.e.rg = rg; v.e.nr = nr; v.e.st = st;
    v.e.ls = ls; v.e.rs = rs; v.e.mo = mo; v.e.win = win;
    v.e.id = 0;
    return v;
  endfunction

  task automatic chk(string name, int id, logic [3:0] got, logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (row %0d): got %0h expected %0h", name, id, got, exp);
    end
  endtask

  task automatic compare_outputs();
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb_q.pop_front();
    chk("l_grant",    e.id, {3'b0, bus.l_grant},    {3'b0, e.lg});
    chk("r_grant",    e.id, {3'b0, bus.r_grant},    {3'b0, e.rg});
    chk("next_round", e.id, {3'b0, bus.next_round}, {3'b0, e.nr});
    chk("state",      e.id, {2'b0, bus.state_o},    {2'b0, e.st});
    chk("l_score",    e.id, {1'b0, bus.l_score},    {1'b0, e.ls});
    chk("r_score",    e.id, {1'b0, bus.r_score},    {1'b0, e.rs});
    chk("match_over", e.id, {3'b0, bus.match_over}, {3'b0, e.mo});
    chk("winner",     e.id, {2'b0, bus.winner},     {2'b0, e.win});
    $display("row %0d: lreq=%0b rreq=%0b lg=%0b rg=%0b nr=%0b st=%0d ls=%0d rs=%0d mo=%0b win=%0b",
             e.id, bus.l_req, bus.r_req, bus.l_grant, bus.r_grant, bus.next_round,
             bus.state_o, bus.l_score, bus.r_score, bus.match_over, bus.winner);
  endtask

  // Raises reset a couple of ns after a rising edge and checks the outputs
  // before the next edge, so only an asynchronous clear can satisfy it.
  // A press is held during reset to confirm grants stay low.
  task automatic reset_pulse(int id);
    exp_t e;
    bus.l_req = 1'b0; bus.r_req = 1'b1; bus.left_edge = 1'b0; bus.right_edge = 1'b1;
    reset = 1'b1;
    e = '{lg:1'b0, rg:1'b0, nr:1'b0, st:2'd0, ls:3'd0, rs:3'd0, mo:1'b0, win:2'b00, id:id};
    sb_q.push_back(e);
    #2;
    compare_outputs();
    @(posedge clk);
    #1;
    bus.r_req = 1'b0; bus.right_edge = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.l_req = 1'b0; bus.r_req = 1'b0; bus.left_edge = 1'b0; bus.right_edge = 1'b0;

    // Segment A: hold-off, human point, cancel, win to DONE.
    //               rst l r le re  lg rg nr st ls rs mo win
    vecs.push_back(mk(1, 1,0,0,0,   0,0,0, 0, 0,0, 0,2'b00)); // HOLD, press dropped
    vecs.push_back(mk(0, 0,1,0,0,   0,0,0, 0, 0,0, 0,2'b00));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0, 0, 0,0, 0,2'b00));
    vecs.push_back(mk(0, 1,0,1,0,   0,0,0, 0, 0,0, 0,2'b00)); // last HOLD cycle
    vecs.push_back(mk(0, 0,1,0,1,   0,1,0, 1, 0,0, 0,2'b00)); // PLAY, human point
    vecs.push_back(mk(0, 0,0,0,0,   0,0,1, 2, 0,1, 0,2'b00)); // SCORE
    vecs.push_back(mk(0, 0,1,0,1,   0,0,0, 0, 0,1, 0,2'b00)); // HOLD again
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0, 0, 0,1, 0,2'b00));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0, 0, 0,1, 0,2'b00));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0, 0, 0,1, 0,2'b00));
    vecs.push_back(mk(0, 1,1,1,1,   0,0,0, 1, 0,1, 0,2'b00)); // cancel
    vecs.push_back(mk(0, 1,0,0,0,   1,0,0, 1, 0,1, 0,2'b00)); // grant, no edge
    vecs.push_back(mk(0, 0,1,0,1,   0,1,0, 1, 0,1, 0,2'b00)); // 2nd human point
    vecs.push_back(mk(0, 0,0,0,0,   0,0,1, 2, 0,2, 0,2'b00));
    vecs.push_back(mk(0, 1,0,1,0,   0,0,0, 3, 0,2, 1,2'b01)); // DONE
    vecs.push_back(mk(0, 0,1,0,1,   0,0,0, 3, 0,2, 1,2'b01));
    // Segment B: reset from DONE, then a timeout draw after 5 PLAY cycles.
    vecs.push_back(mk(1, 0,0,0,0,   0,0,0, 0, 0,0, 0,2'b00));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0, 0, 0,0, 0,2'b00));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0, 0, 0,0, 0,2'b00));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0, 0, 0,0, 0,2'b00));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0,0,0,0, 0,0,0, 1, 0,0, 0,2'b00)); // PLAY x5
    vecs.push_back(mk(0, 0,0,0,0,   0,0,1, 2, 0,0, 0,2'b00)); // draw SCORE
    // Segment C: left point lands on the timeout cycle and still counts.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0,0,0,0, 0,0,0, 0, 0,0, 0,2'b00)); // HOLD x4
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0,0,0,0, 0,0,0, 1, 0,0, 0,2'b00)); // PLAY x4
    vecs.push_back(mk(0, 1,0,1,0,   1,0,0, 1, 0,0, 0,2'b00)); // 5th PLAY, point
    vecs.push_back(mk(0, 0,0,0,0,   0,0,1, 2, 1,0, 0,2'b00));
    vecs.push_back(mk(0, 0,0,0,0,   0,0,0, 0, 1,0, 0,2'b00));

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      if (vecs[i].do_reset) reset_pulse(1000 + i);
      bus.l_req      = vecs[i].l;
      bus.r_req      = vecs[i].r;
      bus.left_edge  = vecs[i].le;
      bus.right_edge = vecs[i].re;
      e = vecs[i].e;
      e.id = i;
      sb_q.push_back(e);
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      #1;
    end

    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
